// File: rtl/traffic_gen_mc.sv
// Multi-channel NoC traffic injector: per-channel LFSR generator, show-ahead queue, saturating statistics.
// Optional TG_SELF_CHECK_EN adds rx destination inputs and counts misrouted arrivals in o_err_count.

// Show-ahead FIFO; the head entry is presented combinationally from storage.
// Latency: an entry written at edge t is at the head in cycle t+1 when the FIFO was empty.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
module tg_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

// Traffic injector top: one generator + queue per router input channel.
// Latency: packet generated in cycle t is at the channel head in t+1 if its queue was empty.
// Backpressure: i_en gates pops; generation into a full, non-popping queue is dropped and counted.
module traffic_gen_mc #(
   parameter int          CHANNELS    = 5,
   parameter int          X_NODES     = 4,
   parameter int          Y_NODES     = 4,
   parameter int          X_LOC       = 0,
   parameter int          Y_LOC       = 0,
   parameter int          RATE_PCT    = 30,
   parameter int          BURST_LEN   = 1,
   parameter int          QUEUE_DEPTH = 8,
   parameter int          ANT_PERIOD  = 100,
   parameter int          CNT_W       = 32,
   parameter logic [15:0] SEED        = 16'hACE1,
   localparam int         XW          = $clog2(X_NODES + 1),
   localparam int         YW          = $clog2(Y_NODES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_start,
   input  logic [CHANNELS-1:0]    i_en,
   input  logic [CHANNELS-1:0]    i_rx_val,
`ifdef TG_SELF_CHECK_EN
   input  logic [CHANNELS*XW-1:0] i_rx_x_dest,
   input  logic [CHANNELS*YW-1:0] i_rx_y_dest,
`endif
   output logic [CHANNELS-1:0]    o_data_val,
   output logic [CHANNELS*XW-1:0] o_x_src,
   output logic [CHANNELS*YW-1:0] o_y_src,
   output logic [CHANNELS*XW-1:0] o_x_dest,
   output logic [CHANNELS*YW-1:0] o_y_dest,
   output logic [CHANNELS-1:0]    o_ant,
   output logic                   o_busy,
   output logic [CNT_W-1:0]       o_gen_count,
   output logic [CNT_W-1:0]       o_tx_count,
   output logic [CNT_W-1:0]       o_rx_count,
   output logic [CNT_W-1:0]       o_drop_count,
   output logic [CNT_W-1:0]       o_err_count
);
   localparam logic [15:0]   LFSR_MASK = 16'hB400;
   localparam int            ENT_W     = 1 + YW + XW;
   localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int            PW        = (ANT_PERIOD > 1) ? $clog2(ANT_PERIOD) : 1;
   localparam bit            MULTI     = (BURST_LEN > 1);
   localparam bit            ANT_EN    = (ANT_PERIOD != 0);
   localparam logic [7:0]    RATE8     = 8'(RATE_PCT);
   localparam logic [15:0]   XN16      = 16'(X_NODES);
   localparam logic [15:0]   YN16      = 16'(Y_NODES);
   localparam logic [XW-1:0] XLOC_V    = XW'(X_LOC);
   localparam logic [YW-1:0] YLOC_V    = YW'(Y_LOC);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctl_state_t;
   typedef enum logic {GEN_IDLE, GEN_BURST} gen_state_t;

   ctl_state_t          state;
   logic                run;
   logic [31:0]         time_cnt;
   logic [PW-1:0]       ant_phase;
   logic                ant_now;
   logic [CHANNELS-1:0] head_vld;
   logic [CHANNELS-1:0] push_vld;
   logic [CHANNELS-1:0] pop_vld;
   logic [CHANNELS-1:0] drop_vld;

   // Headroom in the CNT_W+1 sum assumes CHANNELS < 2**CNT_W.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [CHANNELS-1:0] ev);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt};
      for (int i = 0; i < CHANNELS; i++) sum = sum + (CNT_W+1)'(ev[i]);
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   assign run     = (state == RUN);
   assign o_busy  = (state != IDLE);
   assign ant_now = ANT_EN && (ant_phase == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (i_start) state <= RUN;
            RUN:     if (!i_start) state <= DRAIN;
            DRAIN:   if (i_start) state <= RUN;
                     else if (head_vld == '0) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ant_phase tracks time_cnt % ANT_PERIOD, restarting when the 32-bit time wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         time_cnt  <= '0;
         ant_phase <= '0;
      end else begin
         time_cnt  <= time_cnt + 1'b1;
         ant_phase <= (time_cnt == '1 || ant_phase == PW'(ANT_PERIOD - 1)) ? '0 : ant_phase + 1'b1;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam logic [31:0] SEED_MUL = 32'h1F35 * (c + 1);
      localparam logic [15:0] SEED_RAW = SEED ^ SEED_MUL[15:0];
      localparam logic [15:0] SEED_C   = (SEED_RAW == 16'h0) ? 16'h0001 : SEED_RAW;

      logic [15:0]      lfsr;
      logic [6:0]       trig_pct;
      logic             trig;
      logic [XW-1:0]    x_dest;
      logic [YW-1:0]    y_dest;
      gen_state_t       gen_st;
      logic [BW-1:0]    remain;
      logic [ENT_W-1:0] push_dat;
      logic [ENT_W-1:0] head_dat;
      logic             q_empty;
      logic             q_full;

      always_ff @(posedge clk) begin
         if (reset) lfsr <= SEED_C;
         else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
      end

      assign trig_pct = 7'(({7'd0, lfsr[15:8]} * 15'd100) >> 8);
      assign trig     = ({1'b0, trig_pct} < RATE8);
      assign x_dest   = XW'(({8'd0, lfsr[7:0]} * XN16) >> 8);
      assign y_dest   = YW'(({8'd0, lfsr[11:4]} * YN16) >> 8);

      // The trigger cycle emits the first packet; GEN_BURST emits the remaining BURST_LEN-1.
      assign push_vld[c] = run && ((gen_st == GEN_IDLE && trig) || gen_st == GEN_BURST);
      assign push_dat    = {ant_now, y_dest, x_dest};

      always_ff @(posedge clk) begin
         if (reset || !run) begin
            gen_st <= GEN_IDLE;
            remain <= '0;
         end else if (gen_st == GEN_IDLE) begin
            if (MULTI && trig) begin
               gen_st <= GEN_BURST;
               remain <= BW'(BURST_LEN - 1);
            end
         end else begin
            remain <= remain - 1'b1;
            if (remain == BW'(1)) gen_st <= GEN_IDLE;
         end
      end

      tg_fifo #(.WIDTH(ENT_W), .DEPTH(QUEUE_DEPTH)) u_q (
         .clk      (clk),
         .reset    (reset),
         .push     (push_vld[c]),
         .push_dat (push_dat),
         .pop      (pop_vld[c]),
         .head_dat (head_dat),
         .empty    (q_empty),
         .full     (q_full)
      );

      assign head_vld[c] = ~q_empty;
      assign pop_vld[c]  = ~q_empty & i_en[c];
      assign drop_vld[c] = push_vld[c] & q_full & ~pop_vld[c];

      assign o_data_val[c]         = ~q_empty;
      assign o_ant[c]              = ~q_empty & head_dat[ENT_W-1];
      assign o_x_dest[c*XW +: XW]  = q_empty ? '0 : head_dat[XW-1:0];
      assign o_y_dest[c*YW +: YW]  = q_empty ? '0 : head_dat[XW +: YW];
      assign o_x_src[c*XW +: XW]   = q_empty ? '0 : XLOC_V;
      assign o_y_src[c*YW +: YW]   = q_empty ? '0 : YLOC_V;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_gen_count  <= '0;
         o_tx_count   <= '0;
         o_rx_count   <= '0;
         o_drop_count <= '0;
      end else begin
         o_gen_count  <= sat_add(o_gen_count, push_vld);
         o_tx_count   <= sat_add(o_tx_count, pop_vld);
         o_rx_count   <= sat_add(o_rx_count, i_rx_val);
         o_drop_count <= sat_add(o_drop_count, drop_vld);
      end
   end

`ifdef TG_SELF_CHECK_EN
   logic [CHANNELS-1:0] err_vld;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_err
      assign err_vld[c] = i_rx_val[c] & ((i_rx_x_dest[c*XW +: XW] != XLOC_V) |
                                         (i_rx_y_dest[c*YW +: YW] != YLOC_V));
   end

   always_ff @(posedge clk) begin
      if (reset) o_err_count <= '0;
      else       o_err_count <= sat_add(o_err_count, err_vld);
   end
`else
   assign o_err_count = '0;
`endif
endmodule

// File: doc/traffic_gen_mc.md
Name: traffic_gen_mc

Overview:
- Synthesizable multi-channel traffic injector and counter block for NoC bring-up and characterisation.
- Replaces simulation-only random stimulus with an LFSR-driven generator per channel, a per-channel injection queue honouring downstream enable, and hardware packet statistics.
- Sits between a node/test harness and a router's input ports; one channel per router input.
- Supports Bernoulli or fixed-burst traffic and periodic ant marking.

Parameters:
CHANNELS, 5, number of independent injection channels
X_NODES, 4, mesh width; destination x range 0..X_NODES-1
Y_NODES, 4, mesh height; destination y range 0..Y_NODES-1
X_LOC, 0, x coordinate stamped as source
Y_LOC, 0, y coordinate stamped as source
RATE_PCT, 30, offered load in percent, 0..100
BURST_LEN, 1, packets per trigger; 1 = Bernoulli mode
QUEUE_DEPTH, 8, per-channel queue entries, power of two >= 2
ANT_PERIOD, 100, cycles between ant-marked generation slots; 0 disables ants
CNT_W, 32, statistics counter width
SEED, 16'hACE1, base LFSR seed

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_start  in  1  level; high = generate traffic
i_en  in  CHANNELS  downstream ready per channel
i_rx_val  in  CHANNELS  packet received on channel (statistics only)
o_data_val  out  CHANNELS  head packet valid
o_x_src  out  CHANNELS*$clog2(X_NODES+1)  source x per channel
o_y_src  out  CHANNELS*$clog2(Y_NODES+1)  source y per channel
o_x_dest  out  CHANNELS*$clog2(X_NODES+1)  destination x per channel
o_y_dest  out  CHANNELS*$clog2(Y_NODES+1)  destination y per channel
o_ant  out  CHANNELS  ant flag per channel
o_busy  out  1  control FSM not IDLE
o_gen_count  out  CNT_W  total packets generated
o_tx_count  out  CNT_W  total packets accepted downstream
o_rx_count  out  CNT_W  total i_rx_val pulses
o_drop_count  out  CNT_W  total packets dropped on full queue
o_err_count  out  CNT_W  checker errors (see Optional Feature)

Behaviour:
- Reset: all outputs 0, queues empty, FSM IDLE, time counter 0, LFSRs loaded. A reset mid-operation discards all queued packets and clears all counters.
- LFSR: per-channel 16-bit Galois, mask 16'hB400, seed SEED ^ (16'h1F35*(c+1)). If the computed seed is 0, force 16'h0001. Advances every cycle after reset.
- Trigger:
  - trig = ((lfsr[15:8]*100)>>8) < RATE_PCT.
  - RATE_PCT=0 never triggers; RATE_PCT=100 always triggers.
- Destination: x = (lfsr[7:0]*X_NODES)>>8; y = (lfsr[11:4]*Y_NODES)>>8. Results are always in range.
- Control FSM:
  - IDLE -> RUN when i_start=1.
  - RUN -> DRAIN when i_start=0.
  - DRAIN -> RUN when i_start=1.
  - DRAIN -> IDLE when all queues are empty.
- Generation happens only in RUN.
- Per-channel burst FSM:
  - GEN_IDLE -> GEN_BURST on trig, with remain = BURST_LEN-1.
  - GEN_BURST emits one packet per cycle, remain--, and returns to GEN_IDLE when remain=0.
  - Leaving RUN forces GEN_IDLE.
  - BURST_LEN=1 gives exactly one packet per trig cycle.
- Ant flag: set on a generated packet iff ANT_PERIOD!=0 and time%ANT_PERIOD==0. The time counter is free-running and wraps at 2^32.
- Queue: show-ahead FIFO.
  - A packet generated in cycle t appears on the outputs in cycle t+1 if the queue was empty.
  - Pop when o_data_val & i_en.
  - Push and pop in the same cycle are both allowed, including when full: the pop frees space, so no drop occurs.
  - A push while full and not popping is discarded and increments drop_count.
- Output fields are held stable while o_data_val=1 and i_en=0.
- Counters:
  - Each cycle a counter adds the popcount of its events across channels.
  - Counters saturate at 2^CNT_W-1; they do not wrap.
  - Counter registers update at the clock edge and are visible the next cycle.
- o_busy = (FSM != IDLE).

Optional Feature:
TG_SELF_CHECK_EN
- Defined: adds inputs i_rx_x_dest and i_rx_y_dest (same widths as the outputs). Each i_rx_val pulse whose destination != (X_LOC,Y_LOC) increments o_err_count (saturating).
- Undefined: these ports are absent and o_err_count is tied to 0.

Test Plan:
- Reset 3 cycles, i_start=0, i_en all 1 for 50 cycles -> all outputs 0, o_busy=0.
- RATE_PCT=100, BURST_LEN=1, i_en all 1, i_start=1 for 10 cycles then 0 -> o_gen_count=50, o_tx_count=50, o_drop_count=0; o_busy falls within 2 cycles of queues emptying.
- RATE_PCT=100, QUEUE_DEPTH=8, i_en=0, 20 cycles of RUN -> per channel 8 queued and 12 dropped; o_drop_count=60; head fields stable throughout.
- RATE_PCT=100, ANT_PERIOD=4 -> exactly every 4th generated packet per channel has o_ant=1; destinations are always < X_NODES and < Y_NODES.
- Assert reset mid-burst with 5 entries queued -> next cycle all o_data_val=0 and all counters 0.
- TG_SELF_CHECK_EN defined, 3 rx pulses to (X_LOC,Y_LOC) and 2 to (1,1) with X_LOC=Y_LOC=0 -> o_rx_count=5, o_err_count=2.
